// File: rtl/rf_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_access_arbiter_if
// Request/response bundle between one requester and the register-file
// access arbiter. One instance is used per requester port.
//
// Signals:
//   req     requester -> arbiter  access request, held until gnt
//   we      requester -> arbiter  1 = write, 0 = read, valid with req
//   addr    requester -> arbiter  target register address, valid with req
//   wrData  requester -> arbiter  write data, valid with req and we
//   gnt     arbiter -> requester  one-cycle pulse: request accepted and issued
//   rdVld   arbiter -> requester  one-cycle pulse: read response
//   rdErr   arbiter -> requester  qualifies rdVld: the read timed out
//   rdData  arbiter -> requester  read data, held until the next response
//
// Modports:
//   master  the requester side
//   slave   the arbiter side
// ---------------------------------------------------------------------------
interface rf_access_arbiter_if #(
  parameter int WIDTH     = 8,
  parameter int Addr_SIZE = 4
);

  logic                 req;
  logic                 we;
  logic [Addr_SIZE-1:0] addr;
  logic [WIDTH-1:0]     wrData;
  logic                 gnt;
  logic                 rdVld;
  logic                 rdErr;
  logic [WIDTH-1:0]     rdData;

  modport master (
    output req, we, addr, wrData,
    input  gnt, rdVld, rdErr, rdData
  );

  modport slave (
    input  req, we, addr, wrData,
    output gnt, rdVld, rdErr, rdData
  );

endinterface

// File: rtl/rf_access_arbiter.sv
// ---------------------------------------------------------------------------
// rf_access_arbiter
// Two-requester round-robin arbiter and sequencer for the single-port
// register file. Each grant issues exactly one register-file access; read
// data is routed back to the granted port. A watchdog ends reads whose
// data-valid never comes back and reports them with an error flag.
//
// Parameters:
//   WIDTH      register file word width
//   Addr_SIZE  register file address width
//   TIMEOUT    maximum cycles spent waiting for i_rdDVld (1..255)
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    synchronous active-low reset
//   port0      requester 0 (system controller), slave side of the bundle
//   port1      requester 1 (secondary master), slave side of the bundle
//   o_wrEn     register file write enable
//   o_rdEn     register file read enable
//   o_addr     register file address
//   o_wrD      register file write data
//   i_rdD      register file read data
//   i_rdDVld   register file read data valid
// ---------------------------------------------------------------------------
module rf_access_arbiter #(
  parameter int WIDTH     = 8,
  parameter int Addr_SIZE = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rf_access_arbiter_if.slave   port0,
  rf_access_arbiter_if.slave   port1,
  output logic                 o_wrEn,
  output logic                 o_rdEn,
  output logic [Addr_SIZE-1:0] o_addr,
  output logic [WIDTH-1:0]     o_wrD,
  input  logic [WIDTH-1:0]     i_rdD,
  input  logic                 i_rdDVld
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT_RD
  } state_t;

  // Counter value in the last waiting cycle; the response register then
  // shows up TIMEOUT cycles after WAIT_RD was entered.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t               r_state;
  logic                 r_we;
  logic [Addr_SIZE-1:0] r_addr;
  logic [WIDTH-1:0]     r_wrData;
  logic                 r_winner;
  logic                 r_lastGnt;
  logic [7:0]           r_cnt;
  logic                 r_rdVld0;
  logic                 r_rdVld1;
  logic                 r_rdErr0;
  logic                 r_rdErr1;
  logic [WIDTH-1:0]     r_rdData0;
  logic [WIDTH-1:0]     r_rdData1;

  logic                 w_anyReq;
  logic                 w_winner;
  logic                 w_access;

  // Round-robin pick: on a tie the port that was not granted last wins,
  // otherwise the lone requester wins. Only feeds the capture registers.
  always_comb begin
    w_anyReq = port0.req | port1.req;
    w_winner = (port0.req && port1.req) ? ~r_lastGnt : port1.req;
  end

  // Main sequencer: captures the winning request, issues one access, then
  // either returns to IDLE (write) or waits for read data with a watchdog.
  // Read responses are registered and routed to the captured winner.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wrData  <= '0;
      r_winner  <= 1'b0;
      r_lastGnt <= 1'b1;
      r_cnt     <= '0;
      r_rdVld0  <= 1'b0;
      r_rdVld1  <= 1'b0;
      r_rdErr0  <= 1'b0;
      r_rdErr1  <= 1'b0;
      r_rdData0 <= '0;
      r_rdData1 <= '0;
    end else begin
      r_rdVld0 <= 1'b0;
      r_rdVld1 <= 1'b0;
      r_rdErr0 <= 1'b0;
      r_rdErr1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_winner <= w_winner;
            r_we     <= w_winner ? port1.we     : port0.we;
            r_addr   <= w_winner ? port1.addr   : port0.addr;
            r_wrData <= w_winner ? port1.wrData : port0.wrData;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          r_lastGnt <= r_winner;
          r_cnt     <= '0;
          r_state   <= r_we ? IDLE : WAIT_RD;
        end
        WAIT_RD: begin
          // Data-valid wins over an expiring watchdog in the same cycle.
          if (i_rdDVld) begin
            if (r_winner) begin
              r_rdData1 <= i_rdD;
              r_rdVld1  <= 1'b1;
            end else begin
              r_rdData0 <= i_rdD;
              r_rdVld0  <= 1'b1;
            end
            r_state <= IDLE;
          end else if (r_cnt == LP_CNT_LAST) begin
            if (r_winner) begin
              r_rdData1 <= '0;
              r_rdVld1  <= 1'b1;
              r_rdErr1  <= 1'b1;
            end else begin
              r_rdData0 <= '0;
              r_rdVld0  <= 1'b1;
              r_rdErr0  <= 1'b1;
            end
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Grant and register-file strobes decode purely from state and captured
  // registers, so nothing on the request inputs reaches them in the same
  // cycle.
  always_comb begin
    w_access  = (r_state == ACCESS);
    port0.gnt = w_access && !r_winner;
    port1.gnt = w_access &&  r_winner;
    o_wrEn    = w_access &&  r_we;
    o_rdEn    = w_access && !r_we;
    o_addr    = w_access ? r_addr : '0;
    o_wrD     = (w_access && r_we) ? r_wrData : '0;
  end

  // Response side of each bundle comes straight from its registers.
  always_comb begin
    port0.rdVld  = r_rdVld0;
    port0.rdErr  = r_rdErr0;
    port0.rdData = r_rdData0;
    port1.rdVld  = r_rdVld1;
    port1.rdErr  = r_rdErr1;
    port1.rdData = r_rdData1;
  end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_access_arbiter
// Randomized bench for rf_access_arbiter. Two requesters issue random
// reads/writes, the register file answers after a random latency (or never),
// stray data-valid pulses and random resets are injected. A schedule model
// turns each accepted request into the list of output values expected on
// future cycles; every cycle the DUT outputs are compared with that schedule.
// ---------------------------------------------------------------------------
module tb_rf_access_arbiter;

  localparam int W    = 8;
  localparam int A    = 4;
  localparam int T    = 15;
  localparam int NCYC = 3000;
  localparam int ND   = NCYC + T + 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wrEn;
  logic         rdEn;
  logic [A-1:0] addr;
  logic [W-1:0] wrD;
  logic [W-1:0] rdD;
  logic         rdDVld;

  rf_access_arbiter_if #(.WIDTH(W), .Addr_SIZE(A)) p0If ();
  rf_access_arbiter_if #(.WIDTH(W), .Addr_SIZE(A)) p1If ();

  rf_access_arbiter #(.WIDTH(W), .Addr_SIZE(A), .TIMEOUT(T)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .port0    (p0If),
    .port1    (p1If),
    .o_wrEn   (wrEn),
    .o_rdEn   (rdEn),
    .o_addr   (addr),
    .o_wrD    (wrD),
    .i_rdD    (rdD),
    .i_rdDVld (rdDVld)
  );

  always #5 clk = ~clk;

  // Expected output schedule, indexed by cycle.
  bit           eGnt0  [ND];
  bit           eGnt1  [ND];
  bit           eWrEn  [ND];
  bit           eRdEn  [ND];
  logic [A-1:0] eAddr  [ND];
  logic [W-1:0] eWrD   [ND];
  bit           eVld0  [ND];
  bit           eVld1  [ND];
  bit           eErr0  [ND];
  bit           eErr1  [ND];
  logic [W-1:0] eData0 [ND];
  logic [W-1:0] eData1 [ND];
  bit           eRst   [ND];

  // Model state.
  int           freeAt;
  int           lastGnt;
  int           vldCycle;
  logic [W-1:0] vldData;
  logic [W-1:0] held0;
  logic [W-1:0] held1;

  // Requester state.
  bit           pend0, pend1;
  bit           we0, we1;
  logic [A-1:0] addr0, addr1;
  logic [W-1:0] wd0, wd1;

  int total = 0;
  int bad   = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Records a read response for port p appearing at cycle r.
  task automatic scheduleResp(input int p, input int r, input logic [W-1:0] d, input bit e);
    if (p == 0) begin
      eVld0[r] = 1'b1; eData0[r] = d; eErr0[r] = e;
    end else begin
      eVld1[r] = 1'b1; eData1[r] = d; eErr1[r] = e;
    end
  endtask

  // Drives all inputs sampled at the end of cycle c and extends the
  // expected schedule with whatever the arbiter must do as a result.
  task automatic applyStimulus(input int c);
    bit           rstNow;
    int           w;
    int           lat;
    int           r;
    bit           tWe;
    logic [A-1:0] tAddr;
    logic [W-1:0] tWd;

    rstNow = (c < 3) || ($urandom_range(0, 199) == 0);

    // A granted transaction is finished; a requester may start a new one.
    if (pend0 && eGnt0[c]) pend0 = 1'b0;
    if (pend1 && eGnt1[c]) pend1 = 1'b0;
    if (!pend0 && $urandom_range(0, 1) == 0) begin
      pend0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = A'($urandom); wd0 = W'($urandom);
    end
    if (!pend1 && $urandom_range(0, 1) == 0) begin
      pend1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = A'($urandom); wd1 = W'($urandom);
    end
    p0If.req = pend0; p0If.we = we0; p0If.addr = addr0; p0If.wrData = wd0;
    p1If.req = pend1; p1If.we = we1; p1If.addr = addr1; p1If.wrData = wd1;

    // Planned read data, or a stray pulse while the arbiter is idle.
    if (c == vldCycle) begin
      rdDVld = 1'b1;
      rdD    = vldData;
    end else begin
      rdDVld = (c >= freeAt) && ($urandom_range(0, 7) == 0);
      rdD    = W'($urandom);
    end
    rst_n = !rstNow;

    if (rstNow) begin
      for (int k = c + 1; k < ND; k++) begin
        eGnt0[k] = 0; eGnt1[k] = 0; eWrEn[k] = 0; eRdEn[k] = 0;
        eAddr[k] = '0; eWrD[k] = '0; eVld0[k] = 0; eVld1[k] = 0;
        eErr0[k] = 0; eErr1[k] = 0; eRst[k] = 0;
      end
      eRst[c + 1] = 1'b1;
      lastGnt     = 1;
      freeAt      = c + 1;
      vldCycle    = -1;
    end else if (c >= freeAt && (pend0 || pend1)) begin
      if (pend0 && pend1) w = (lastGnt == 1) ? 0 : 1;
      else                w = pend1 ? 1 : 0;
      lastGnt = w;
      tWe   = (w == 1) ? we1   : we0;
      tAddr = (w == 1) ? addr1 : addr0;
      tWd   = (w == 1) ? wd1   : wd0;
      if (w == 0) eGnt0[c + 1] = 1'b1;
      else        eGnt1[c + 1] = 1'b1;
      eAddr[c + 1] = tAddr;
      if (tWe) begin
        eWrEn[c + 1] = 1'b1;
        eWrD[c + 1]  = tWd;
        freeAt       = c + 2;
      end else begin
        eRdEn[c + 1] = 1'b1;
        lat = $urandom_range(0, T + 3);
        if (lat < T) begin
          vldCycle = c + 2 + lat;
          vldData  = W'($urandom);
          r        = vldCycle + 1;
          scheduleResp(w, r, vldData, 1'b0);
        end else begin
          r = c + 2 + T;
          scheduleResp(w, r, '0, 1'b1);
        end
        freeAt = r;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; rdDVld = 1'b0; rdD = '0;
    p0If.req = 0; p0If.we = 0; p0If.addr = '0; p0If.wrData = '0;
    p1If.req = 0; p1If.we = 0; p1If.addr = '0; p1If.wrData = '0;
    freeAt = 0; lastGnt = 1; vldCycle = -1; vldData = '0;
    held0 = '0; held1 = '0;
    pend0 = 0; pend1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        if (eRst[c]) begin held0 = '0; held1 = '0; end
        if (eVld0[c]) held0 = eData0[c];
        if (eVld1[c]) held1 = eData1[c];
        checkOutput("gnt0",    32'(p0If.gnt),    32'(eGnt0[c]));
        checkOutput("gnt1",    32'(p1If.gnt),    32'(eGnt1[c]));
        checkOutput("wrEn",    32'(wrEn),        32'(eWrEn[c]));
        checkOutput("rdEn",    32'(rdEn),        32'(eRdEn[c]));
        checkOutput("addr",    32'(addr),        32'(eAddr[c]));
        checkOutput("wrD",     32'(wrD),         32'(eWrD[c]));
        checkOutput("rdVld0",  32'(p0If.rdVld),  32'(eVld0[c]));
        checkOutput("rdVld1",  32'(p1If.rdVld),  32'(eVld1[c]));
        checkOutput("rdErr0",  32'(p0If.rdErr),  32'(eErr0[c]));
        checkOutput("rdErr1",  32'(p1If.rdErr),  32'(eErr1[c]));
        checkOutput("rdData0", 32'(p0If.rdData), 32'(held0));
        checkOutput("rdData1", 32'(p1If.rdData), 32'(held1));
      end
      applyStimulus(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
